// File: rtl/relogio_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner for an HH-MM-SS clock.
// Each frame shows a snapshot of the time taken at the frame boundary, so
// the digits never tear. Out-of-range fields show 'E'. The field under
// adjustment blinks. A blank guard cycle after each digit change prevents
// ghosting.
module relogio_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [5:0] horas,
    input  logic [5:0] minutos,
    input  logic [5:0] segundos,
    input  logic [1:0] modo_ajuste,
    output logic [7:0] an,
    output logic [7:0] dec_ddp
);

    localparam int PW = $clog2(REFRESH_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Encoding matches modo_ajuste; F_NONE also marks the dash slots.
    typedef enum logic [1:0] {
        F_NONE  = 2'd0,
        F_HOURS = 2'd1,
        F_MIN   = 2'd2,
        F_SEC   = 2'd3
    } field_e;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [1:0]    mode_prev_q;
    logic [5:0]    snap_h_q, snap_h_d, snap_m_q, snap_m_d, snap_s_q, snap_s_d;
    field_e        snap_mode_q, snap_mode_d;
    logic [7:0]    an_q, an_d, seg_q, seg_d;

    logic tick, frame_load, mode_chg;

    assign tick       = (presc_q == PRESC_LAST);
    assign frame_load = tick && (idx_q == 3'd7);
    assign mode_chg   = (modo_ajuste != mode_prev_q);

    // Next-state for prescaler, digit index, blink timer and frame snapshot.
    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        idx_d       = tick ? idx_q + 3'd1 : idx_q;
        snap_h_d    = frame_load ? horas    : snap_h_q;
        snap_m_d    = frame_load ? minutos  : snap_m_q;
        snap_s_d    = frame_load ? segundos : snap_s_q;
        snap_mode_d = frame_load ? field_e'(modo_ajuste) : snap_mode_q;
        if (mode_chg) begin
            // Restart visible so the newly selected field shows at once.
            blink_d = '0;
            phase_d = 1'b1;
        end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + 1'b1;
            phase_d = phase_q;
        end
    end

    // Digit decode for the current slot, with guard and blink blanking.
    always_comb begin
        logic [5:0] val;
        logic [3:0] tens, units;
        logic       bad, use_tens, blank;
        logic [7:0] glyph;
        // NOTE: every variable gets a default first so no path infers a latch.
        field_e     fld;
        fld  = F_NONE;
        val  = '0;
        an_d = 8'hFF;
        seg_d = 8'hFF;
        case (idx_q)
            3'd7, 3'd6: begin fld = F_HOURS; val = snap_h_q; end
            3'd4, 3'd3: begin fld = F_MIN;   val = snap_m_q; end
            3'd1, 3'd0: begin fld = F_SEC;   val = snap_s_q; end
            default:    begin fld = F_NONE;  val = '0;       end
        endcase
        bad      = (fld == F_HOURS) ? (val > 6'd23) : (val > 6'd59);
        tens     = 4'(val / 6'd10);
        units    = 4'(val % 6'd10);
        // Tens sit on odd slots for hours/seconds, on the even slot for minutes.
        use_tens = (fld == F_MIN) ? ~idx_q[0] : idx_q[0];
        if (fld == F_NONE)
            glyph = 8'hBF;
        else if (bad)
            glyph = 8'h86;
        else
            glyph = seg7(use_tens ? tens : units);
        blank = (snap_mode_q != F_NONE) && !phase_q && (snap_mode_q == fld);
        // The slot whose index is about to change is forced dark for one cycle.
        if (!tick && !blank) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = glyph;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_100MHz) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b1;
            mode_prev_q <= 2'd0;
            snap_h_q    <= '0;
            snap_m_q    <= '0;
            snap_s_q    <= '0;
            snap_mode_q <= F_NONE;
            an_q        <= 8'hFF;
            seg_q       <= 8'hFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            mode_prev_q <= modo_ajuste;
            snap_h_q    <= snap_h_d;
            snap_m_q    <= snap_m_d;
            snap_s_q    <= snap_s_d;
            snap_mode_q <= snap_mode_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an      = an_q;
    assign dec_ddp = seg_q;

endmodule

// File: tb/tb_relogio_scan_ctrl.sv
// Directed bench for relogio_scan_ctrl with REFRESH_DIV=4, BLINK_DIV=64:
// one frame is 32 cycles, each slot is one guard cycle plus three lit cycles.
module tb_relogio_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] horas, minutos, segundos;
    logic [1:0] modo_ajuste;
    logic [7:0] an, dec_ddp;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;
    bit mon_en   = 1'b0;
    logic [7:0] an_prev = 8'hFF;

    // Values applied mid-frame by the frame task.
    logic [5:0] n_h, n_m, n_s;
    logic [1:0] n_mode;

    always #5 clk = ~clk;

    relogio_scan_ctrl #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (64)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .horas      (horas),
        .minutos    (minutos),
        .segundos   (segundos),
        .modo_ajuste(modo_ajuste),
        .an         (an),
        .dec_ddp    (dec_ddp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Anode sanity on every cycle: one low bit at most, dark cycle between
    // different digits, segments dark whenever anodes are dark.
    always @(negedge clk) begin
        if (mon_en) begin
            viol <= viol
                + (($countones(~an) > 1) ? 1 : 0)
                + ((an != 8'hFF && an_prev != 8'hFF && an != an_prev) ? 1 : 0)
                + ((an == 8'hFF && dec_ddp != 8'hFF) ? 1 : 0);
            an_prev <= an;
        end
    end

    task automatic wait_slot(input int k, input string tag);
        logic [7:0] pat;
        pat = ~(8'h01 << k);
        for (int i = 0; i < 100 && an !== pat; i++) @(negedge clk);
        check({tag, "_sync"}, an, pat);
    endtask

    // sync 0: next slot 0; sync 1: from slot 7 into the next frame;
    // sync 2: skip one frame via its slot 5. exp holds idx7..idx0 glyphs.
    task automatic frame(input string tag, input int sync, input logic [63:0] exp,
                         input logic [7:0] mask, input int chg_at);
        logic [7:0] pat;
        case (sync)
            0: wait_slot(0, tag);
            1: begin wait_slot(7, tag); repeat (4) @(negedge clk); end
            default: begin wait_slot(5, tag); repeat (12) @(negedge clk); end
        endcase
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                repeat (3) @(negedge clk);
                check($sformatf("%s_guard%0d", tag, k), an, 8'hFF);
                @(negedge clk);
            end
            if (mask[k]) begin
                check($sformatf("%s_an%0d", tag, k), an, 8'hFF);
                check($sformatf("%s_seg%0d", tag, k), dec_ddp, 8'hFF);
            end else begin
                pat = ~(8'h01 << k);
                check($sformatf("%s_an%0d", tag, k), an, pat);
                check($sformatf("%s_seg%0d", tag, k), dec_ddp, exp[k*8+:8]);
            end
            if (k == chg_at) begin
                horas       = n_h;
                minutos     = n_m;
                segundos    = n_s;
                modo_ajuste = n_mode;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] e1207;
        e1207 = {8'hF9, 8'hA4, 8'hBF, 8'hC0, 8'hF8, 8'hBF, 8'h92, 8'h82};
        reset = 1'b1;
        horas = 6'd12; minutos = 6'd34; segundos = 6'd56; modo_ajuste = 2'd0;
        n_h = 6'd0; n_m = 6'd0; n_s = 6'd0; n_mode = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", dec_ddp, 8'hFF);
        reset  = 1'b0;
        mon_en = 1'b1;

        // First frame comes from the zeroed snapshot, second from live inputs.
        frame("f_zero", 0, {8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hC0}, 8'h00, -1);
        frame("f_123456", 1, {8'hF9, 8'hA4, 8'hBF, 8'hB0, 8'h99, 8'hBF, 8'h92, 8'h82}, 8'h00, -1);

        horas = 6'd30; minutos = 6'd59; segundos = 6'd60;
        frame("f_range", 1, {8'h86, 8'h86, 8'hBF, 8'h92, 8'h90, 8'hBF, 8'h86, 8'h86}, 8'h00, -1);

        // Mid-frame change at idx 3 must not reach the later slots of this frame.
        horas = 6'd1; minutos = 6'd10; segundos = 6'd2;
        frame("f_0110", 1, {8'hC0, 8'hF9, 8'hBF, 8'hF9, 8'hC0, 8'hBF, 8'hC0, 8'hA4}, 8'h00, -1);
        n_h = 6'd2; n_m = 6'd11; n_s = 6'd2; n_mode = 2'd0;
        frame("f_midchg", 1, {8'hC0, 8'hF9, 8'hBF, 8'hF9, 8'hC0, 8'hBF, 8'hC0, 8'hA4}, 8'h00, 3);
        frame("f_0211", 1, {8'hC0, 8'hA4, 8'hBF, 8'hF9, 8'hF9, 8'hBF, 8'hC0, 8'hA4}, 8'h00, -1);

        // Minutes blink: 2 frames lit, 2 frames dark, then lit again.
        horas = 6'd12; minutos = 6'd7; segundos = 6'd56; modo_ajuste = 2'd2;
        frame("blk_on0", 2, e1207, 8'h00, -1);
        frame("blk_off", 2, e1207, 8'h18, -1);
        frame("blk_on1", 2, e1207, 8'h00, -1);

        // Switch to seconds while minutes are dark: seconds lit for 64 cycles.
        n_h = 6'd12; n_m = 6'd7; n_s = 6'd56; n_mode = 2'd3;
        frame("blk_off2", 2, e1207, 8'h18, 4);
        frame("sec_vis0", 1, e1207, 8'h00, -1);
        frame("sec_vis1", 1, e1207, 8'h00, -1);
        frame("sec_blk", 1, e1207, 8'h03, -1);

        // One-cycle reset at idx 5: dark at once, then scan restarts from 0.
        wait_slot(5, "rst5");
        reset = 1'b1;
        @(negedge clk);
        check("rst5_an", an, 8'hFF);
        check("rst5_seg", dec_ddp, 8'hFF);
        reset = 1'b0;
        @(negedge clk);
        check("rst5_slot0_an", an, 8'hFE);
        check("rst5_slot0_seg", dec_ddp, 8'hC0);
        repeat (3) @(negedge clk);
        check("rst5_guard_an", an, 8'hFF);
        @(negedge clk);
        check("rst5_slot1_an", an, 8'hFD);
        check("rst5_slot1_seg", dec_ddp, 8'hC0);

        @(negedge clk);
        check("anode_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
